// File: rtl/fft384_twiddle_mul.sv
`default_nettype none
// ============================================================================
//  Module   : fft384_twiddle_mul
//  Brief    : 384-point FFT twiddle stage: carrier indexing for the twiddle ROM,
//             4-stage complex multiply with round-half-up and saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module fft384_twiddle_mul #(
  parameter int D_WIDTH   = 16,
  parameter int TW_WIDTH  = 16,
  parameter int FRAC_BITS = 14,
  parameter int N_PT      = 384,
  parameter int CNT_W     = 9
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [D_WIDTH-1:0]      din_re,
  input  logic [D_WIDTH-1:0]      din_im,
  input  logic                    din_vld,
  input  logic                    din_sop,
  output logic [CNT_W-1:0]        tw_num,
  output logic                    tw_num_vld,
  input  logic [2*TW_WIDTH-1:0]   tw_data,
  input  logic                    tw_vld,
  output logic [D_WIDTH-1:0]      dout_re,
  output logic [D_WIDTH-1:0]      dout_im,
  output logic                    dout_vld,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic                    sat_flag,
  output logic                    tw_err
);

  localparam int c_PW = D_WIDTH + TW_WIDTH;
  localparam int c_AW = c_PW + 1;
  localparam logic [CNT_W-1:0]       c_LAST = CNT_W'(N_PT - 1);
  localparam logic signed [c_AW-1:0] c_HALF = c_AW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [c_AW-1:0] c_MAX  = c_AW'(2 ** (D_WIDTH - 1) - 1);
  localparam logic signed [c_AW-1:0] c_MIN  = ~c_MAX;

  // Carrier counter; the ROM registers tw_num at the same edge as stage A.
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx;

  assign w_idx      = din_sop ? '0 : r_idx;
  assign tw_num     = w_idx;
  assign tw_num_vld = din_vld;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_idx <= '0;
    end else if (din_vld) begin
      r_idx <= (w_idx == c_LAST) ? '0 : w_idx + CNT_W'(1);
    end
  end

  // Stage A: sample and framing, waiting for the ROM word.
  logic signed [D_WIDTH-1:0] r_a_re, r_a_im;
  logic                      r_a_vld, r_a_sop, r_a_eop;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_a_re  <= '0;
      r_a_im  <= '0;
      r_a_vld <= 1'b0;
      r_a_sop <= 1'b0;
      r_a_eop <= 1'b0;
    end else begin
      r_a_re  <= din_re;
      r_a_im  <= din_im;
      r_a_vld <= din_vld;
      r_a_sop <= din_vld && (w_idx == '0);
      r_a_eop <= din_vld && (w_idx == c_LAST);
    end
  end

  // Stage B: partial products against the now-valid twiddle word.
  logic signed [TW_WIDTH-1:0] w_cos, w_sin;
  logic signed [c_PW-1:0]     r_b_ac, r_b_bs, r_b_as, r_b_bc;
  logic                       r_b_vld, r_b_sop, r_b_eop;
  logic                       r_tw_err;

  assign w_cos = tw_data[2*TW_WIDTH-1:TW_WIDTH];
  assign w_sin = tw_data[TW_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_b_ac   <= '0;
      r_b_bs   <= '0;
      r_b_as   <= '0;
      r_b_bc   <= '0;
      r_b_vld  <= 1'b0;
      r_b_sop  <= 1'b0;
      r_b_eop  <= 1'b0;
      r_tw_err <= 1'b0;
    end else begin
      r_b_ac  <= r_a_re * w_cos;
      r_b_bs  <= r_a_im * w_sin;
      r_b_as  <= r_a_re * w_sin;
      r_b_bc  <= r_a_im * w_cos;
      r_b_vld <= r_a_vld;
      r_b_sop <= r_a_sop;
      r_b_eop <= r_a_eop;
      if (tw_vld != r_a_vld) begin
        r_tw_err <= 1'b1;
      end
    end
  end

  // Stage C: complex sums in one extra bit of headroom.
  logic signed [c_AW-1:0] r_c_re, r_c_im;
  logic                   r_c_vld, r_c_sop, r_c_eop;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_c_re  <= '0;
      r_c_im  <= '0;
      r_c_vld <= 1'b0;
      r_c_sop <= 1'b0;
      r_c_eop <= 1'b0;
    end else begin
      r_c_re  <= c_AW'(r_b_ac) - c_AW'(r_b_bs);
      r_c_im  <= c_AW'(r_b_as) + c_AW'(r_b_bc);
      r_c_vld <= r_b_vld;
      r_c_sop <= r_b_sop;
      r_c_eop <= r_b_eop;
    end
  end

  // Returns {clipped, value}.
  function automatic logic [D_WIDTH:0] round_sat(input logic signed [c_AW-1:0] acc);
    logic signed [c_AW-1:0] rnd;
    rnd = (acc + c_HALF) >>> FRAC_BITS;
    if (rnd > c_MAX) begin
      round_sat = {1'b1, D_WIDTH'(c_MAX)};
    end else if (rnd < c_MIN) begin
      round_sat = {1'b1, D_WIDTH'(c_MIN)};
    end else begin
      round_sat = {1'b0, D_WIDTH'(rnd)};
    end
  endfunction

  logic [D_WIDTH:0] w_re_sat, w_im_sat;

  always_comb begin
    w_re_sat = round_sat(r_c_re);
    w_im_sat = round_sat(r_c_im);
  end

  // Stage D: data holds through bubbles, flags are gated by valid.
  logic [D_WIDTH-1:0] r_dout_re, r_dout_im;
  logic               r_dout_vld, r_dout_sop, r_dout_eop, r_sat_flag;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_dout_re  <= '0;
      r_dout_im  <= '0;
      r_dout_vld <= 1'b0;
      r_dout_sop <= 1'b0;
      r_dout_eop <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      r_dout_vld <= r_c_vld;
      r_dout_sop <= r_c_vld & r_c_sop;
      r_dout_eop <= r_c_vld & r_c_eop;
      r_sat_flag <= r_c_vld & (w_re_sat[D_WIDTH] | w_im_sat[D_WIDTH]);
      if (r_c_vld) begin
        r_dout_re <= w_re_sat[D_WIDTH-1:0];
        r_dout_im <= w_im_sat[D_WIDTH-1:0];
      end
    end
  end

  assign dout_re  = r_dout_re;
  assign dout_im  = r_dout_im;
  assign dout_vld = r_dout_vld;
  assign dout_sop = r_dout_sop;
  assign dout_eop = r_dout_eop;
  assign sat_flag = r_sat_flag;
  assign tw_err   = r_tw_err;

endmodule
`default_nettype wire

// File: doc/fft384_twiddle_mul.md
Name: fft384_twiddle_mul

Overview:
Twiddle-multiply stage of the 384-point FFT decoder datapath, sitting directly downstream of the twiddle ROM. Tracks the carrier index (0-383) of the incoming sample stream and drives it to the ROM as the lookup address. Realigns each sample with the ROM's 1-cycle-late {cos,sin} word, then complex-multiplies the two. Rounds and saturates the product back to sample width and forwards it with symbol framing flags.

Parameters:
D_WIDTH, 16, signed width of each sample component (re/im)
TW_WIDTH, 16, signed twiddle component width, Q1.14 format (0x4000 = +1.0, 0xC000 = -1.0)
FRAC_BITS, 14, twiddle fraction bits removed after multiply
N_PT, 384, carriers per symbol
CNT_W, 9, carrier counter width

Ports:
clk  in  1  clock
n_rst  in  1  reset; synchronous, active-low
din_re  in  D_WIDTH  sample real part, signed
din_im  in  D_WIDTH  sample imaginary part, signed
din_vld  in  1  sample valid
din_sop  in  1  first carrier of symbol; qualified by din_vld
tw_num  out  CNT_W  carrier number to twiddle ROM (0-383)
tw_num_vld  out  1  ROM lookup valid
tw_data  in  2*TW_WIDTH  ROM output {cos,sin}; arrives 1 cycle after tw_num
tw_vld  in  1  ROM output valid
dout_re  out  D_WIDTH  product real part
dout_im  out  D_WIDTH  product imaginary part
dout_vld  out  1  output valid
dout_sop  out  1  first carrier of symbol
dout_eop  out  1  carrier 383
sat_flag  out  1  this output word was saturated (re or im); qualified by dout_vld
tw_err  out  1  sticky ROM/pipeline valid misalignment

Behaviour:
- Reset:
  - Synchronous, active-low; takes effect at the clk edge with n_rst=0.
  - Clears idx_r, all pipeline valid/sop/eop bits, all outputs and tw_err to 0.
  - In-flight samples are dropped. No dout_vld for 3 cycles after release unless new input arrives.
- Carrier counter idx_r:
  - idx = din_sop ? 0 : idx_r. This is combinational.
  - tw_num = idx and tw_num_vld = din_vld, both combinational, so the ROM registers the lookup at the same edge.
  - On each edge with din_vld=1: idx_r <= (idx==N_PT-1) ? 0 : idx+1.
  - With din_vld=0, idx_r holds.
  - Without din_sop the counter free-runs, wrapping 383->0.
  - din_sop mid-symbol restarts at 0. The truncated symbol gets no eop.
- Pipeline (sample accepted at edge E):
  - E, stage A: register din_re, din_im, vld, sop = (idx==0), eop = (idx==N_PT-1).
  - E+1, stage B:
    - tw_data is valid in this cycle. Register the four signed products a*c, b*d, a*s, b*c, each D_WIDTH+TW_WIDTH bits.
    - Operand mapping: a=re, b=im, c=cos, s=sin, i.e. b*c uses im*cos and the imaginary sum uses im*cos.
    - If tw_vld != stage-A vld, set tw_err=1. tw_err stays set until reset.
  - E+2, stage C: re_acc = a*c - b*s; im_acc = a*s + b*c. Each is 33 bits, sign-extended.
  - E+3, stage D:
    - Round: (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up).
    - Saturate to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
    - Register dout_re, dout_im, dout_vld, dout_sop, dout_eop, and sat_flag (either component clipped).
  - Result: dout = din × (cos + j·sin) exactly, no conjugation.
  - Latency is fixed at 3 cycles after the sampling edge. Throughput is 1 sample/cycle.
  - Bubbles (din_vld gaps) propagate unchanged.
- Outputs when dout_vld=0:
  - dout_re and dout_im hold their last value.
  - dout_sop, dout_eop and sat_flag are forced to 0.
- No backpressure: downstream must accept every dout_vld word.

Test Plan:
- Reset, then 384 consecutive valid samples with din_sop on the first → tw_num sequence 0..383 with tw_num_vld high. dout_vld is high 384 cycles starting 3 cycles after the first input. dout_sop on output 0, dout_eop on output 383. tw_err=0.
- din=(10000,0), tw_data={0x3B20,0x187D} → dout=(9238,3826), sat_flag=0. din=(0,10000), same tw → dout=(-3826,9238).
- din=(-32768,0), tw_data={0xC000,0x0000} (-1.0) → re saturates to 32767, im=0, sat_flag=1. din=(-32768,-32768), tw={0x2D41,0x2D41} → dout=(0,-32768), sat_flag=1.
- 400 valid samples, din_sop only on the first → counter wraps 383->0. Output 384 has dout_sop=1, output 383 has dout_eop=1. din_sop asserted at index 200 → next output index 0, no eop emitted for the aborted symbol.
- Random din_vld gaps (50% duty) → tw_num holds across gaps, outputs match the golden model in order, latency 3 cycles per sample.
- n_rst low for 1 cycle while 3 samples in flight → no dout_vld for those samples, next tw_num=0. tw_vld held low while a sample is in stage B → tw_err=1 and stays 1 until the next reset.
